// File: rtl/ins_prefetch_unit.sv
// Purpose: instruction fetch unit that keeps one memory request outstanding and fills a DEPTH-entry prefetch FIFO for decode.
// Latency: mem_req_out rises 1 cycle after the issue condition holds; a word acked in cycle N appears at ins_out in cycle N+1.
// Backpressure: fetch stalls on a full FIFO or wait_for_next_in; dequeue is stalled by !ins_ready_in or freeze.
// Build option: define IFU_COMM_DECODE_EN to trap Start/Stop/End communication words (COMM/HALT states).

// Generic prefetch FIFO with flush, registered storage and an occupancy count.
// Latency: a pushed entry is visible at head_dat on the next cycle; pop takes effect at the clock edge.
// Backpressure: none internally; the caller never pushes into a full FIFO unless it pops in the same cycle.
module ifu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally at DEPTH (power of two); flush empties the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// Instruction fetch FSM with PC redirect/flush in front of the prefetch FIFO.
// Latency: request one cycle after issue condition; FIFO head registered, one cycle after ack.
// Backpressure: stops issuing when FIFO full or wait_for_next_in; ins_ready_in/freeze hold the head.
module ins_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    input  logic            wait_for_next_in,
    input  logic            freeze,
    output logic            mem_req_out,
    output logic [XLEN-1:0] mem_addr_out,
    input  logic            mem_ack_in,
    input  logic [ILEN-1:0] mem_data_in,
    output logic            ins_valid_out,
    input  logic            ins_ready_in,
    output logic [ILEN-1:0] ins_out,
    output logic [XLEN-1:0] npc_out,
    output logic            communication_enable_out,
    output logic [18:0]     communication_signal_out
);
    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(ILEN / 8);

    typedef struct packed {
        logic [ILEN-1:0] ins;
        logic [XLEN-1:0] npc;
    } entry_t;

`ifdef IFU_COMM_DECODE_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_COMM = 2'd2,
        S_HALT = 2'd3
    } state_t;
`else
    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc_nxt;
    logic [XLEN-1:0] pc_inc;
    logic            drop;
    logic            drop_nxt;
    logic            push_vld;
    logic            pop_vld;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_post;
    logic            issue_now;
    logic            issue_post;
    entry_t          push_ent;
    entry_t          head_ent;

`ifdef IFU_COMM_DECODE_EN
    logic            is_comm;
    logic            trap_vld;
    logic            comm_fire;
    logic [18:0]     comm_word;
    logic            comm_en_q;
    logic [18:0]     comm_sig_q;

    // Opcode 111111 marks communication words; [18:17]=01 is an ordinary instruction.
    assign is_comm = (mem_data_in[31:26] == 6'b111111) && (mem_data_in[18:17] != 2'b01);
`endif

    assign pc_inc        = fetch_pc + PC_STEP;
    assign ins_valid_out = (count != '0);
    assign pop_vld       = ins_valid_out && ins_ready_in && !freeze && !redirect_valid_in;
    assign count_post    = count + CW'(1) - CW'(pop_vld);
    assign issue_now     = !wait_for_next_in && (count < FULL_CNT) && !redirect_valid_in;
    assign issue_post    = !wait_for_next_in && (count_post < FULL_CNT);

    assign push_ent.ins  = mem_data_in;
    assign push_ent.npc  = pc_inc;

    assign mem_req_out   = (state == S_REQ);
    assign mem_addr_out  = mem_req_out ? req_pc : '0;
    assign ins_out       = head_ent.ins;
    assign npc_out       = head_ent.npc;

    ifu_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect_valid_in),
        .push_vld (push_vld),
        .push_dat (push_ent),
        .pop_vld  (pop_vld),
        .head_dat (head_ent),
        .count    (count)
    );

    // Next-state and datapath control; a redirect overrides every other action this cycle.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        drop_nxt     = drop;
        push_vld     = 1'b0;
`ifdef IFU_COMM_DECODE_EN
        trap_vld     = 1'b0;
        comm_fire    = 1'b0;
`endif
        if (redirect_valid_in) begin
            fetch_pc_nxt = redirect_pc_in;
            if ((state == S_REQ) && !mem_ack_in) begin
                // The request cannot be withdrawn: stay in REQ and swallow its response.
                drop_nxt = 1'b1;
            end else begin
                drop_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_now) begin
                        state_nxt  = S_REQ;
                        req_pc_nxt = fetch_pc;
                    end
                end
                S_REQ: begin
                    if (mem_ack_in) begin
                        if (drop) begin
                            drop_nxt  = 1'b0;
                            state_nxt = S_IDLE;
                        end else begin
                            fetch_pc_nxt = pc_inc;
`ifdef IFU_COMM_DECODE_EN
                            if (is_comm) begin
                                trap_vld  = 1'b1;
                                state_nxt = S_COMM;
                            end else
`endif
                            begin
                                push_vld = 1'b1;
                                if (issue_post) begin
                                    req_pc_nxt = pc_inc;
                                end else begin
                                    state_nxt = S_IDLE;
                                end
                            end
                        end
                    end
                end
`ifdef IFU_COMM_DECODE_EN
                S_COMM: begin
                    // Older instructions must drain to decode before the unit is told.
                    if (count == '0) begin
                        comm_fire = 1'b1;
                        state_nxt = (comm_word[18:17] == 2'b10) ? S_IDLE : S_HALT;
                    end
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
`endif
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC, address held on the memory bus, and pending-drop flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
            drop     <= drop_nxt;
        end
    end

`ifdef IFU_COMM_DECODE_EN
    // Held trap word plus the registered pulse and signal towards the Communication Unit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            comm_word  <= '0;
            comm_en_q  <= 1'b0;
            comm_sig_q <= '0;
        end else begin
            comm_en_q <= comm_fire;
            if (redirect_valid_in) begin
                comm_word <= '0;
            end else if (trap_vld) begin
                comm_word <= mem_data_in[18:0];
            end
            if (comm_fire) comm_sig_q <= comm_word;
        end
    end

    assign communication_enable_out = comm_en_q;
    assign communication_signal_out = comm_sig_q;
`else
    assign communication_enable_out = 1'b0;
    assign communication_signal_out = '0;
`endif
endmodule

// File: tb/tb_ins_prefetch_unit.sv
// Randomised and directed bench for ins_prefetch_unit against a queue-based reference model.
// Latency: one stimulus step per clock; outputs sampled and inputs driven on the falling edge.
// Backpressure: memory latency, ins_ready_in, freeze, wait_for_next_in and redirects are all exercised.
module tb_ins_prefetch_unit;
    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            redirect_valid_in = 1'b0;
    logic [XLEN-1:0] redirect_pc_in = '0;
    logic            wait_for_next_in = 1'b0;
    logic            freeze = 1'b0;
    logic            mem_req_out;
    logic [XLEN-1:0] mem_addr_out;
    logic            mem_ack_in = 1'b0;
    logic [ILEN-1:0] mem_data_in = '0;
    logic            ins_valid_out;
    logic            ins_ready_in = 1'b0;
    logic [ILEN-1:0] ins_out;
    logic [XLEN-1:0] npc_out;
    logic            communication_enable_out;
    logic [18:0]     communication_signal_out;

    ins_prefetch_unit #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .redirect_valid_in        (redirect_valid_in),
        .redirect_pc_in           (redirect_pc_in),
        .wait_for_next_in         (wait_for_next_in),
        .freeze                   (freeze),
        .mem_req_out              (mem_req_out),
        .mem_addr_out             (mem_addr_out),
        .mem_ack_in               (mem_ack_in),
        .mem_data_in              (mem_data_in),
        .ins_valid_out            (ins_valid_out),
        .ins_ready_in             (ins_ready_in),
        .ins_out                  (ins_out),
        .npc_out                  (npc_out),
        .communication_enable_out (communication_enable_out),
        .communication_signal_out (communication_signal_out)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected decode stream as a queue, next fetch PC, redirect epochs.
    typedef struct {
        logic [31:0] ins;
        logic [31:0] npc;
    } ent_t;
    ent_t        q[$];
    logic [31:0] exp_pc;
    int          epoch;
    bit          comm_pend, halted, exp_en;
    logic [18:0] comm_w, exp_sig;

    // Memory model state.
    bit          m_act;
    int          m_left;
    logic [31:0] m_addr;
    int          m_epoch;
    int          lat_min = 1, lat_max = 1;
    logic [31:0] data_q[$];
    int          ack_cnt, deq_count, cyc;

    // Stimulus knobs and per-step observations.
    logic        st_ready = 1'b0, st_freeze = 1'b0, st_wait = 1'b0, st_redir = 1'b0;
    logic [31:0] st_redir_pc = '0;
    logic        prev_wait, prev_redir;
    bit          s_deq, s_new_req, s_pulse;
    logic [31:0] s_npc, s_new_addr;

    function automatic bit is_trap(input logic [31:0] w);
`ifdef IFU_COMM_DECODE_EN
        return (w[31:26] == 6'h3F) && (w[18:17] != 2'b01);
`else
        return (w[31:26] == 6'h3F) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
`ifdef IFU_COMM_DECODE_EN
        if (w[31:26] == 6'h3F) w[26] = 1'b0;
`endif
        return w;
    endfunction

    task automatic model_init();
        q.delete();
        data_q.delete();
        exp_pc = RESET_PC; epoch = 0;
        comm_pend = 0; halted = 0; exp_en = 0; exp_sig = '0; comm_w = '0;
        m_act = 0; m_left = 0; m_addr = '0; m_epoch = 0;
        prev_wait = 1'b0; prev_redir = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ack_in = 1'b0;
        redirect_valid_in = 1'b0;
        ins_ready_in = st_ready;
        freeze = st_freeze;
        wait_for_next_in = st_wait;
        repeat (2) @(negedge clock);
        chk("rst_mem_req", mem_req_out, 0);
        chk("rst_mem_addr", mem_addr_out, 0);
        chk("rst_ins_valid", ins_valid_out, 0);
        chk("rst_ins_out", ins_out, 0);
        chk("rst_npc_out", npc_out, 0);
        chk("rst_comm_en", communication_enable_out, 0);
        chk("rst_comm_sig", communication_signal_out, 0);
        model_init();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock of stimulus: check outputs against the model, drive inputs, advance the model.
    task automatic step();
        logic        ack;
        logic [31:0] d;
        bit          deq, fire;
        @(negedge clock);
        cyc++;
        s_deq = 0; s_new_req = 0; s_pulse = communication_enable_out;
        chk("ins_valid", ins_valid_out, q.size() != 0);
        chk("comm_en", communication_enable_out, exp_en);
        chk("comm_sig", communication_signal_out, exp_sig);
        exp_en = 0;
        if (q.size() != 0) chk("ins_out", ins_out, q[0].ins);

        ack = 1'b0;
        d   = rand_word();
        if (mem_req_out) begin
            if (!m_act) begin
                m_act = 1; m_addr = mem_addr_out; m_epoch = epoch;
                m_left = $urandom_range(lat_max, lat_min);
                s_new_req = 1; s_new_addr = mem_addr_out;
                chk("req_gate", {prev_wait, prev_redir}, 2'b00);
                chk("req_room", q.size() < DEPTH, 1);
                chk("req_not_halted", comm_pend | halted, 0);
                chk("req_addr", mem_addr_out, exp_pc);
            end else begin
                chk("req_hold", mem_addr_out, m_addr);
            end
            if (m_left == 0) begin
                ack = 1'b1; m_act = 0; ack_cnt++;
                if (data_q.size() != 0) d = data_q.pop_front();
            end else begin
                m_left--;
            end
        end else if (m_act) begin
            chk("req_withdrawn", mem_req_out, 1);
            m_act = 0;
        end

        mem_ack_in        = ack;
        mem_data_in       = ack ? d : $urandom;
        ins_ready_in      = st_ready;
        freeze            = st_freeze;
        wait_for_next_in  = st_wait;
        redirect_valid_in = st_redir;
        redirect_pc_in    = st_redir_pc;

        deq = (q.size() != 0) && st_ready && !st_freeze && !st_redir;
        if (deq) begin
            chk("npc_out", npc_out, q[0].npc);
            s_deq = 1; s_npc = npc_out; deq_count++;
        end

        if (st_redir) begin
            q.delete(); epoch++; exp_pc = st_redir_pc;
            comm_pend = 0; halted = 0;
        end else begin
            fire = comm_pend && (q.size() == 0);
            if (deq) void'(q.pop_front());
            if (fire) begin
                exp_en = 1; exp_sig = comm_w; comm_pend = 0;
                halted = (comm_w[18:17] != 2'b10);
            end
            if (ack && (m_epoch == epoch)) begin
                exp_pc = m_addr + 32'd4;
                if (is_trap(d)) begin
                    comm_pend = 1; comm_w = d[18:0];
                end else begin
                    q.push_back('{d, m_addr + 32'd4});
                end
            end
        end
        prev_wait  = st_wait;
        prev_redir = st_redir;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          dq0, acks0, spacing[$];
        logic [31:0] npcs[$];
        bit          got;
        logic [31:0] first_addr, first_npc;

        model_init();

        // Straight-line fetch with a 1-cycle memory: one instruction every two cycles.
        st_ready = 1; lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 40 && npcs.size() < 3; i++) begin
            step();
            if (s_deq) begin npcs.push_back(s_npc); spacing.push_back(cyc); end
        end
        if (npcs.size() < 3) chk("straight_timeout", npcs.size(), 3);
        else begin
            chk("straight_npc0", npcs[0], 32'h104);
            chk("straight_npc1", npcs[1], 32'h108);
            chk("straight_npc2", npcs[2], 32'h10C);
            chk("straight_rate_a", spacing[1] - spacing[0], 2);
            chk("straight_rate_b", spacing[2] - spacing[1], 2);
        end

        // Same-cycle memory: one instruction per cycle.
        lat_min = 0; lat_max = 0;
        npcs.delete(); spacing.delete();
        do_reset();
        for (int i = 0; i < 40 && npcs.size() < 3; i++) begin
            step();
            if (s_deq) begin npcs.push_back(s_npc); spacing.push_back(cyc); end
        end
        if (npcs.size() < 3) chk("fast_timeout", npcs.size(), 3);
        else begin
            chk("fast_rate_a", spacing[1] - spacing[0], 1);
            chk("fast_rate_b", spacing[2] - spacing[1], 1);
        end

        // Backpressure: exactly DEPTH words accepted, then requests stop until decode drains.
        st_ready = 0; lat_min = 1; lat_max = 1;
        do_reset();
        ack_cnt = 0;
        repeat (30) step();
        chk("bp_acks", ack_cnt, DEPTH);
        chk("bp_req_idle", mem_req_out, 0);
        st_ready = 1;
        repeat (30) step();
        chk("bp_resume", ack_cnt > DEPTH + 4, 1);

        // Redirect to 0x2000 while the request for 0x10C is still unacked.
        st_ready = 0; lat_min = 3; lat_max = 3;
        do_reset();
        got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            step();
            if (m_act && (m_addr == 32'h10C) && (m_left > 0)) got = 1;
        end
        chk("redir_setup", got, 1);
        st_redir = 1; st_redir_pc = 32'h2000; st_ready = 1;
        step();
        st_redir = 0;
        first_addr = '0; first_npc = '0;
        for (int i = 0; i < 40 && first_npc == 0; i++) begin
            step();
            if (s_new_req && first_addr == 0) first_addr = s_new_addr;
            if (s_deq && first_npc == 0) first_npc = s_npc;
        end
        chk("redir_first_addr", first_addr, 32'h2000);
        chk("redir_first_npc", first_npc, 32'h2004);

        // Freeze with a full FIFO: head holds and nothing dequeues.
        st_ready = 0; lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 40 && q.size() < DEPTH; i++) step();
        chk("freeze_full", q.size(), DEPTH);
        st_ready = 1; st_freeze = 1;
        dq0 = deq_count;
        repeat (8) step();
        chk("freeze_no_deq", deq_count - dq0, 0);
        st_freeze = 0;
        repeat (20) step();

        // wait_for_next_in held high: no request ever issues.
        st_wait = 1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step();
            chk("wait_no_req", mem_req_out, 0);
        end
        st_wait = 0;

`ifdef IFU_COMM_DECODE_EN
        // Start behind two buffered instructions, then End halts fetch until a redirect.
        st_ready = 0; lat_min = 1; lat_max = 1;
        do_reset();
        data_q = '{32'h0000_0013, 32'h0000_0093, 32'hFC04_0000, 32'h0000_0113, 32'hFC00_0000};
        for (int i = 0; i < 40 && !comm_pend; i++) step();
        chk("start_trapped", comm_pend, 1);
        chk("start_behind_two", q.size(), 2);
        st_ready = 1;
        dq0 = deq_count; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (s_pulse) begin
                got = 1;
                chk("start_deq_before_pulse", deq_count - dq0, 2);
                chk("start_signal", communication_signal_out, 19'h40000);
            end
        end
        chk("start_pulse_seen", got, 1);
        for (int i = 0; i < 60 && !halted; i++) step();
        chk("end_halted", halted, 1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("halt_no_req", mem_req_out, 0);
        end
        st_redir = 1; st_redir_pc = 32'h3000;
        step();
        st_redir = 0;
        got = 0; first_addr = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (s_new_req) begin got = 1; first_addr = s_new_addr; end
        end
        chk("halt_redirect_addr", first_addr, 32'h3000);
`else
        // Communication-format words are ordinary instructions in this build.
        st_ready = 1; lat_min = 1; lat_max = 1;
        do_reset();
        data_q = '{32'hFC00_0000, 32'hFC06_0000};
        dq0 = deq_count;
        repeat (10) step();
        chk("comm_word_enqueued", deq_count - dq0 >= 2, 1);
`endif

        // Randomised traffic against the model.
        lat_min = 0; lat_max = 2;
        st_ready = 1; st_freeze = 0; st_wait = 0; st_redir = 0;
        do_reset();
        acks0 = ack_cnt;
        for (int i = 0; i < 1500; i++) begin
            st_ready    = ($urandom_range(3, 0) != 0);
            st_freeze   = ($urandom_range(9, 0) == 0);
            st_wait     = ($urandom_range(9, 0) == 0);
            st_redir    = ($urandom_range(39, 0) == 0);
            st_redir_pc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step();
        end
        st_redir = 0; st_freeze = 0; st_wait = 0;
        chk("random_progress", ack_cnt - acks0 > 300, 1);

        // Asynchronous reset in the middle of a request with a non-empty FIFO.
        st_ready = 0; lat_min = 3; lat_max = 3;
        do_reset();
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (m_act && q.size() >= 2) got = 1;
        end
        chk("arst_setup", got, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_req", mem_req_out, 0);
        chk("arst_mem_addr", mem_addr_out, 0);
        chk("arst_ins_valid", ins_valid_out, 0);
        chk("arst_ins_out", ins_out, 0);
        chk("arst_npc_out", npc_out, 0);
        do_reset();
        got = 0; first_addr = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (s_new_req) begin got = 1; first_addr = s_new_addr; end
        end
        chk("arst_first_addr", first_addr, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
